// File: rtl/vga_pixel_out.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_out
//  Description : VGA timing generator and pixel output stage. Pops one RGB word
//                from a first-word-fall-through FIFO per HREP visible pixels and
//                drives registered RGB / HS / VS / blank to the DAC, with a
//                sticky underflow flag for pops attempted on an empty FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_out #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HREP     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_ce,
   input  logic [23:0] fifo_rd_data,
   input  logic        fifo_empty,
   output logic        fifo_rd_en,
   output logic [23:0] vga_rgb,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        frame_start,
   output logic        underflow
);

   localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int C_H_W     = $clog2(C_H_TOTAL);
   localparam int C_V_W     = $clog2(C_V_TOTAL);

   localparam logic [C_H_W-1:0] C_H_LAST   = C_H_W'(C_H_TOTAL - 1);
   localparam logic [C_H_W-1:0] C_H_ACT    = C_H_W'(H_ACTIVE);
   localparam logic [C_H_W-1:0] C_HS_BEG   = C_H_W'(H_ACTIVE + H_FP);
   localparam logic [C_H_W-1:0] C_HS_END   = C_H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [C_H_W-1:0] C_REP_MASK = C_H_W'(HREP - 1);
   localparam logic [C_V_W-1:0] C_V_LAST   = C_V_W'(C_V_TOTAL - 1);
   localparam logic [C_V_W-1:0] C_V_ACT    = C_V_W'(V_ACTIVE);
   localparam logic [C_V_W-1:0] C_VS_BEG   = C_V_W'(V_ACTIVE + V_FP);
   localparam logic [C_V_W-1:0] C_VS_END   = C_V_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [C_H_W-1:0] r_h_cnt;
   logic [C_V_W-1:0] r_v_cnt;
   logic [23:0]      r_hold;

   logic w_active;
   logic w_grp_start;
   logic w_fetch;
   logic w_hs_n;
   logic w_vs_n;
   logic w_frame0;

   // Decode of the current raster position; HREP is a power of two so the
   // group start is a simple mask test.
   assign w_active    = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
   assign w_grp_start = (r_h_cnt & C_REP_MASK) == '0;
   assign w_hs_n      = !((r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END));
   assign w_vs_n      = !((r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END));
   assign w_frame0    = (r_h_cnt == '0) && (r_v_cnt == '0);

   // Gated by rst_n so no pop strobe can leak out while reset is held.
   assign w_fetch     = rst_n && pix_ce && w_active && w_grp_start;
   assign fifo_rd_en  = w_fetch && !fifo_empty;

   // Raster counters: horizontal wraps at the line total and steps the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (pix_ce) begin
         if (r_h_cnt == C_H_LAST) begin
            r_h_cnt <= '0;
            if (r_v_cnt == C_V_LAST) begin
               r_v_cnt <= '0;
            end else begin
               r_v_cnt <= r_v_cnt + 1'b1;
            end
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
      end
   end

   // Registered DAC outputs, pixel hold register and sticky underflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_rgb     <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
         r_hold      <= '0;
      end else begin
         // Pulse lasts one clk even when ticks are sparse.
         frame_start <= pix_ce && w_frame0;
         if (pix_ce) begin
            vga_hs      <= w_hs_n;
            vga_vs      <= w_vs_n;
            vga_blank_n <= w_active;
            if (!w_active) begin
               vga_rgb <= '0;
            end else if (w_grp_start) begin
               if (fifo_empty) begin
                  // Missing word: show black for the whole group.
                  vga_rgb   <= '0;
                  r_hold    <= '0;
                  underflow <= 1'b1;
               end else begin
                  vga_rgb <= fifo_rd_data;
                  r_hold  <= fifo_rd_data;
               end
            end else begin
               vga_rgb <= r_hold;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pixel_out
//  Description : Self-checking bench for vga_pixel_out. A reduced-geometry
//                instance is checked cycle by cycle against a raster model
//                computed from the tick count; a full 640x480 instance is
//                checked over its first line.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_pixel_out;

   localparam int H_ACTIVE = 64;
   localparam int H_FP     = 4;
   localparam int H_SYNC   = 8;
   localparam int H_BP     = 4;
   localparam int V_ACTIVE = 12;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 3;
   localparam int HREP     = 8;
   localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        pix_ce;
   logic        fifo_empty;
   logic [23:0] fifo_rd_data;
   logic        fifo_rd_en;
   logic [23:0] vga_rgb;
   logic        vga_hs, vga_vs, vga_blank_n, frame_start, underflow;

   vga_pixel_out #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HREP(HREP)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
      .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .vga_rgb(vga_rgb), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .frame_start(frame_start), .underflow(underflow)
   );

   // Full-size instance with default 640x480 timing, free-running ticks.
   logic        rst_n_f = 1'b0;
   logic        rd_f;
   logic [23:0] rgb_f;
   logic        hs_f, vs_f, blank_f, fs_f, uf_f;
   logic        full_done = 1'b0;

   vga_pixel_out u_dut_full (
      .clk(clk), .rst_n(rst_n_f), .pix_ce(1'b1),
      .fifo_rd_data(24'hA1B2C3), .fifo_empty(1'b0), .fifo_rd_en(rd_f),
      .vga_rgb(rgb_f), .vga_hs(hs_f), .vga_vs(vs_f), .vga_blank_n(blank_f),
      .frame_start(fs_f), .underflow(uf_f)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: tick count since reset plus the expected outputs.
   int          m_n, m_h, m_v;
   logic [23:0] m_rgb, m_word;
   logic        m_hs, m_vs, m_blank, m_fs, m_uf;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [28:0] pack_out();
      return {vga_rgb, vga_hs, vga_vs, vga_blank_n, frame_start, underflow};
   endfunction

   task automatic model_reset();
      m_n = 0; m_h = 0; m_v = 0;
      m_rgb = '0; m_word = '0;
      m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b0; m_fs = 1'b0; m_uf = 1'b0;
   endtask

   // One clk: drive inputs, check the pop strobe, then check registered outputs.
   task automatic cycle(input logic ce, input logic empty, input logic [23:0] data,
                        output logic rd_obs);
      int   h, v;
      logic act, grp, exp_rd;
      @(negedge clk);
      pix_ce = ce; fifo_empty = empty; fifo_rd_data = data;
      h   = m_n % HT;
      v   = (m_n / HT) % VT;
      act = (h < H_ACTIVE) && (v < V_ACTIVE);
      grp = act && (h % HREP == 0);
      exp_rd = ce && grp && !empty;
      #1;
      rd_obs = fifo_rd_en;
      check("fifo_rd_en", fifo_rd_en, exp_rd);
      @(posedge clk);
      m_fs = 1'b0;
      if (ce) begin
         m_h = h; m_v = v;
         m_blank = act;
         m_hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
         m_vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
         m_fs = (h == 0) && (v == 0);
         if (grp) begin
            m_word = empty ? 24'h0 : data;
            if (empty) m_uf = 1'b1;
         end
         m_rgb = act ? m_word : 24'h0;
         m_n++;
      end
      #1;
      check("outputs", pack_out(), {m_rgb, m_hs, m_vs, m_blank, m_fs, m_uf});
   endtask

   typedef struct {
      logic        empty;
      logic [23:0] data;
      logic [23:0] exp_rgb;
      logic        exp_uf;
   } grp_t;

   typedef struct {
      logic        ce;
      logic        empty;
      logic [23:0] data;
      logic [23:0] exp_rgb;
      logic        exp_rd;
      logic        exp_uf;
   } vec_t;

   grp_t grp_tab[4];
   vec_t vec[32];

   initial begin : main
      logic        rd;
      logic [28:0] snap;
      int fs_seen, fs_last, hs_run, hs_start, vs_ticks;
      logic prev_vs;

      // Line-start groups: two good words, one empty fetch, then a refill.
      grp_tab[0] = '{1'b0, 24'h112233, 24'h112233, 1'b0};
      grp_tab[1] = '{1'b0, 24'h445566, 24'h445566, 1'b0};
      grp_tab[2] = '{1'b1, 24'hDEADBE, 24'h000000, 1'b1};
      grp_tab[3] = '{1'b0, 24'h778899, 24'h778899, 1'b1};
      for (int g = 0; g < 4; g++)
         for (int k = 0; k < 8; k++)
            vec[g*8+k] = '{1'b1, grp_tab[g].empty, grp_tab[g].data, grp_tab[g].exp_rgb,
                           (k == 0) && !grp_tab[g].empty, grp_tab[g].exp_uf};

      rst_n = 1'b0; pix_ce = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", pack_out(), {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      check("reset_rd_en", fifo_rd_en, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed line-start sequence.
      for (int i = 0; i < 32; i++) begin
         cycle(vec[i].ce, vec[i].empty, vec[i].data, rd);
         check("vec_rd_en", rd, vec[i].exp_rd);
         check("vec_rgb", vga_rgb, vec[i].exp_rgb);
         check("vec_underflow", underflow, vec[i].exp_uf);
      end

      // Ticks every second clk, FIFO never empty: frame period and sync widths.
      fs_seen = 0; fs_last = -1; hs_run = 0; hs_start = -1; vs_ticks = 0;
      prev_vs = 1'b1;
      for (int i = 0; i < 2 * (2 * HT * VT + 64) && fs_seen < 2; i++) begin
         cycle(logic'(i % 2), 1'b0, 24'($urandom), rd);
         if (i % 2 == 1) begin
            if (frame_start) begin
               if (fs_last >= 0) begin
                  check("frame_period", m_n - fs_last, HT * VT);
                  check("vs_low_ticks", vs_ticks, V_SYNC * HT);
               end
               fs_last = m_n; fs_seen++; vs_ticks = 0;
            end
            if (!vga_vs) begin
               vs_ticks++;
               if (prev_vs) check("vs_start_line", m_v, V_ACTIVE + V_FP);
            end
            prev_vs = vga_vs;
            if (!vga_hs) begin
               if (hs_run == 0) hs_start = m_h;
               hs_run++;
            end else if (hs_run > 0) begin
               check("hs_width", hs_run, H_SYNC);
               check("hs_start", hs_start, H_ACTIVE + H_FP);
               hs_run = 0;
            end
         end
      end
      check("frame_pulses", fs_seen, 2);

      // Random ticks with rare empty fetches.
      for (int i = 0; i < 3000; i++)
         cycle(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 199) == 0),
               24'($urandom), rd);

      // Stall mid-line for 100 clks; nothing may move.
      for (int i = 0; i < 2 * HT && (m_n % HT) != 20; i++)
         cycle(1'b1, 1'b0, 24'($urandom), rd);
      cycle(1'b0, 1'b0, 24'($urandom), rd);
      snap = pack_out();
      for (int i = 0; i < 100; i++)
         cycle(1'b0, logic'($urandom_range(0, 1)), 24'($urandom), rd);
      check("stall_hold", pack_out(), snap);
      for (int i = 0; i < 40; i++)
         cycle(1'b1, 1'b0, 24'($urandom), rd);

      // Asynchronous reset mid-frame with a tick still asserted.
      pix_ce = 1'b1; fifo_empty = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", pack_out(), {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      check("async_reset_rd_en", fifo_rd_en, 1'b0);
      model_reset();
      pix_ce = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 1'b0, 24'h0A0B0C, rd);
      check("restart_frame_start", frame_start, 1'b1);
      for (int i = 0; i < 2000; i++)
         cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 299) == 0),
               24'($urandom), rd);

      for (int i = 0; i < 2000 && !full_done; i++) @(negedge clk);
      if (!full_done) begin
         n_tests++; n_fail++;
         $display("FAIL full_instance_timeout: got not-done expected done");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // First line of the full-size instance: sync position, visible width, pops.
   initial begin : full_chk
      int hs_low, hs_first, blank_hi, pops;
      hs_low = 0; hs_first = -1; blank_hi = 0; pops = 0;
      repeat (2) @(negedge clk);
      rst_n_f = 1'b1;
      for (int j = 0; j <= 800; j++) begin
         #1;
         if (j < 800 && rd_f) pops++;
         if (j >= 1) begin
            if (!hs_f) begin
               hs_low++;
               if (hs_first < 0) hs_first = j - 1;
            end
            if (blank_f) blank_hi++;
         end
         if (j == 1) check("full_first_pixel", rgb_f, 24'hA1B2C3);
         @(negedge clk);
      end
      check("full_hs_width", hs_low, 96);
      check("full_hs_start", hs_first, 656);
      check("full_visible", blank_hi, 640);
      check("full_pops_per_line", pops, 80);
      check("full_vs_idle", vs_f, 1'b1);
      check("full_underflow", uf_f, 1'b0);
      full_done = 1'b1;
   end

endmodule
`default_nettype wire
